// File: rtl/riscv_mv_pkg.sv
// Shared RVMV types: element widths, config targets,
// config request bundle and config FSM states.
package riscv_mv_pkg;

  typedef enum logic [1:0] {
    EW4  = 2'b00,
    EW8  = 2'b01,
    EW16 = 2'b10,
    EW32 = 2'b11
  } vew_e;

  typedef enum logic [1:0] {
    NONECFG = 2'b00,
    MCFG    = 2'b01,
    VCFG    = 2'b10,
    ACFG    = 2'b11
  } cfg_func3_e;

  typedef struct packed {
    cfg_func3_e  target;
    vew_e        ew;
    logic [31:0] avl;
  } mv_cfg_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_UPDATE = 2'b10,
    ST_RESP   = 2'b11
  } mv_cfg_state_e;

  localparam int DEF_VLEN  = 1024;
  localparam int DEF_MLEN  = 4096;
  localparam int DEF_ALEN  = 2048;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/mv_inflight_cnt.sv
// Saturating up/down count of MV operations in flight,
// with full and zero flags for dispatch and drain.
module mv_inflight_cnt #(
  parameter int CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_up;
  logic             w_dn;

  assign w_up = inc_i & ~dec_i & (r_cnt != MAX);
  assign w_dn = dec_i & ~inc_i & (r_cnt != '0);

  // Count issues up and retires down, clamped at both ends
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_up) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dn) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign full_o = (r_cnt == MAX);
  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/mv_cfg_unit.sv
// OPCFG stage: drains in-flight MV ops, then updates the
// per-class element width / length CSRs and responds.
module mv_cfg_unit
  import riscv_mv_pkg::*;
#(
  parameter int VLEN  = DEF_VLEN,
  parameter int MLEN  = DEF_MLEN,
  parameter int ALEN  = DEF_ALEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [1:0]  cfg_target_i,
  input  logic [1:0]  cfg_ew_i,
  input  logic [31:0] cfg_avl_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_vl_o,
  output logic        resp_err_o,
  input  logic        op_issue_i,
  input  logic        op_retire_i,
  output logic        inflight_full_o,
  output logic        busy_o,
  output logic [1:0]  vew_o,
  output logic [1:0]  mew_o,
  output logic [1:0]  aew_o,
  output logic [31:0] vl_o,
  output logic [31:0] ml_o,
  output logic [31:0] al_o
);

  mv_cfg_state_e r_state;
  mv_cfg_req_t   r_req;
  logic          r_resp_valid;
  logic [31:0]   r_resp_vl;
  logic          r_resp_err;
  vew_e          r_vew;
  vew_e          r_mew;
  vew_e          r_aew;
  logic [31:0]   r_vl;
  logic [31:0]   r_ml;
  logic [31:0]   r_al;

  logic          w_zero;
  logic          w_full;
  logic [31:0]   w_len;
  logic [2:0]    w_sh;
  logic [31:0]   w_vlmax;
  logic [31:0]   w_grant;

  mv_inflight_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (op_issue_i),
    .dec_i  (op_retire_i),
    .full_o (w_full),
    .zero_o (w_zero)
  );

  // Register-class length for the latched target
  always_comb begin
    w_len = 32'd0;
    unique case (1'b1)
      (r_req.target == MCFG): w_len = 32'(MLEN);
      (r_req.target == VCFG): w_len = 32'(VLEN);
      (r_req.target == ACFG): w_len = 32'(ALEN);
      default:                w_len = 32'd0;
    endcase
  end

  assign w_sh    = {1'b0, r_req.ew} + 3'd2;
  assign w_vlmax = w_len >> w_sh;
  assign w_grant = (r_req.avl < w_vlmax) ? r_req.avl : w_vlmax;

  // Config FSM with registered response and CSR state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_vl    <= 32'd0;
      r_resp_err   <= 1'b0;
      r_vew        <= EW8;
      r_mew        <= EW8;
      r_aew        <= EW8;
      r_vl         <= 32'd0;
      r_ml         <= 32'd0;
      r_al         <= 32'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            r_req.target <= cfg_func3_e'(cfg_target_i);
            r_req.ew     <= vew_e'(cfg_ew_i);
            r_req.avl    <= cfg_avl_i;
            if (cfg_func3_e'(cfg_target_i) == NONECFG) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_vl    <= 32'd0;
              r_state      <= ST_RESP;
            end else begin
              r_resp_err <= 1'b0;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_zero) begin
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          unique case (1'b1)
            (r_req.target == MCFG): begin
              r_mew <= r_req.ew;
              r_ml  <= w_grant;
            end
            (r_req.target == VCFG): begin
              r_vew <= r_req.ew;
              r_vl  <= w_grant;
            end
            (r_req.target == ACFG): begin
              r_aew <= r_req.ew;
              r_al  <= w_grant;
            end
            default: ;
          endcase
          r_resp_vl    <= w_grant;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready_o     = (r_state == ST_IDLE) & ~rst_i;
  assign busy_o          = (r_state != ST_IDLE);
  assign resp_valid_o    = r_resp_valid;
  assign resp_vl_o       = r_resp_vl;
  assign resp_err_o      = r_resp_err;
  assign inflight_full_o = w_full;
  assign vew_o           = r_vew;
  assign mew_o           = r_mew;
  assign aew_o           = r_aew;
  assign vl_o            = r_vl;
  assign ml_o            = r_ml;
  assign al_o            = r_al;

endmodule
